// File: rtl/neo_pkg.sv
// rtl/neo_pkg.sv - shared constants, state type and channel order helper for the frame sequencer
//
// Purpose : common definitions imported by the sequencer, its frame store and
//           the controller-link interface.
// Contents: channel index constants, FSM state type, pixel/level widths and
//           the load-step to channel mapping used while streaming a pixel.
package neo_pkg;

    localparam int PIXEL_IDX_W = 3;
    localparam int LEVEL_W     = 8;

    localparam logic [1:0] COLOR_RED   = 2'd0;
    localparam logic [1:0] COLOR_BLUE  = 2'd1;
    localparam logic [1:0] COLOR_GREEN = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        HOLD = 2'd3
    } seq_state_t;

    // The strand expects each pixel as green, red, blue; step counts 0..2
    // through that order so the counter itself resets to 0.
    function automatic logic [1:0] step_to_color(input logic [1:0] step);
        case (step)
            2'd0:    step_to_color = COLOR_GREEN;
            2'd1:    step_to_color = COLOR_RED;
            default: step_to_color = COLOR_BLUE;
        endcase
    endfunction

endpackage

// File: rtl/neo_frame_sequencer_if.sv
// rtl/neo_frame_sequencer_if.sv - sequencer to strand-controller load/send link
//
// Purpose : groups the per-channel load handshake and the send handshake.
// Signals : load_color/ready_to_load  - one colour level accepted per cycle
//                                        when both are high
//           color_index, pixel_index,
//           color_level               - address and value of the load
//           send_it/ready_to_send     - latch the loaded pixels onto the strand
// Modports: master = sequencer, slave = strand controller.
interface neo_frame_sequencer_if;
    import neo_pkg::*;

    logic                   load_color;
    logic [1:0]             color_index;
    logic [PIXEL_IDX_W-1:0] pixel_index;
    logic [LEVEL_W-1:0]     color_level;
    logic                   send_it;
    logic                   ready_to_load;
    logic                   ready_to_send;

    modport master (
        output load_color, color_index, pixel_index, color_level, send_it,
        input  ready_to_load, ready_to_send
    );

    modport slave (
        input  load_color, color_index, pixel_index, color_level, send_it,
        output ready_to_load, ready_to_send
    );

endinterface

// File: rtl/neo_frame_store.sv
// rtl/neo_frame_store.sv - register-array frame memory, synchronous write, combinational read
//
// Purpose : holds NUM_FRAMES x NUM_PIXELS x {R,B,G} colour levels.
// Ports   : clock, reset_n               - clock, async active-low clear of all entries
//           wr_en, wr_frame, wr_pixel,
//           wr_color, wr_data            - host write; out-of-range pixel or
//                                          channel 3 is dropped
//           rd_frame, rd_pixel, rd_color - read address
//           rd_data                      - read value (0 for out-of-range address)
module neo_frame_store
    import neo_pkg::*;
#(
    parameter int NUM_PIXELS = 5,
    parameter int NUM_FRAMES = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_FRAMES)-1:0] wr_frame,
    input  logic [PIXEL_IDX_W-1:0]        wr_pixel,
    input  logic [1:0]                    wr_color,
    input  logic [LEVEL_W-1:0]            wr_data,
    input  logic [$clog2(NUM_FRAMES)-1:0] rd_frame,
    input  logic [PIXEL_IDX_W-1:0]        rd_pixel,
    input  logic [1:0]                    rd_color,
    output logic [LEVEL_W-1:0]            rd_data
);

    localparam int FW    = $clog2(NUM_FRAMES);
    localparam int DEPTH = NUM_FRAMES * NUM_PIXELS * 3;
    localparam int AW    = $clog2(DEPTH);

    logic [LEVEL_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_addr;
    logic [AW-1:0]      rd_addr;
    logic               wr_ok;
    logic               rd_ok;

    // Flat layout: frame-major, then pixel, then channel index.
    function automatic logic [AW-1:0] addr_of(input logic [FW-1:0]          f,
                                              input logic [PIXEL_IDX_W-1:0] p,
                                              input logic [1:0]             c);
        int a;
        a = (int'(f) * NUM_PIXELS + int'(p)) * 3 + int'(c);
        return AW'(a);
    endfunction

    assign wr_ok   = wr_en && (int'(wr_pixel) < NUM_PIXELS) && (wr_color != 2'd3);
    assign rd_ok   = (int'(rd_pixel) < NUM_PIXELS) && (rd_color != 2'd3);
    assign wr_addr = addr_of(wr_frame, wr_pixel, wr_color);
    assign rd_addr = addr_of(rd_frame, rd_pixel, rd_color);

    // A read of a location being written this cycle sees the old value.
    assign rd_data = rd_ok ? mem[rd_addr] : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/neo_frame_sequencer.sv
// rtl/neo_frame_sequencer.sv - plays stored colour frames into the NeoPixel strand controller
//
// Purpose : on start, streams frame 0 as per-channel loads, issues a send,
//           holds for hold_cycles+1 cycles, then moves to the next frame,
//           optionally looping, until the last frame or a stop.
// Ports   : clock, reset_n                 - clock, async active-low reset
//           wr_en/wr_frame/wr_pixel/
//           wr_color/wr_data               - host write into the frame store
//           start, stop, loop_en           - playback control
//           num_frames_m1                  - last frame index, sampled at start
//           hold_cycles                    - hold length, sampled when a send is accepted
//           ctl                            - load/send link to the strand controller
//           running, frame_idx, frame_done - playback status
module neo_frame_sequencer
    import neo_pkg::*;
#(
    parameter int NUM_PIXELS = 5,
    parameter int NUM_FRAMES = 4,
    parameter int HOLD_W     = 24
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_FRAMES)-1:0] wr_frame,
    input  logic [PIXEL_IDX_W-1:0]        wr_pixel,
    input  logic [1:0]                    wr_color,
    input  logic [LEVEL_W-1:0]            wr_data,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          loop_en,
    input  logic [$clog2(NUM_FRAMES)-1:0] num_frames_m1,
    input  logic [HOLD_W-1:0]             hold_cycles,
    neo_frame_sequencer_if.master         ctl,
    output logic                          running,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
    output logic                          frame_done
);

    localparam int FW = $clog2(NUM_FRAMES);
    localparam logic [PIXEL_IDX_W-1:0] LAST_PIXEL = PIXEL_IDX_W'(NUM_PIXELS - 1);

    seq_state_t             state_q, state_d;
    logic [FW-1:0]          frame_q, last_q;
    logic [PIXEL_IDX_W-1:0] pixel_q;
    logic [1:0]             step_q;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_len_q;
    logic                   stop_pend_q;
    logic                   load_acc, send_acc, last_load, finish;
    logic [1:0]             color_now;

    assign color_now       = step_to_color(step_q);
    assign ctl.pixel_index = pixel_q;
    assign ctl.color_index = color_now;
    assign running         = (state_q != IDLE);
    assign frame_idx       = frame_q;

    neo_frame_store #(
        .NUM_PIXELS (NUM_PIXELS),
        .NUM_FRAMES (NUM_FRAMES)
    ) u_store (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_frame (wr_frame),
        .wr_pixel (wr_pixel),
        .wr_color (wr_color),
        .wr_data  (wr_data),
        .rd_frame (frame_q),
        .rd_pixel (pixel_q),
        .rd_color (color_now),
        .rd_data  (ctl.color_level)
    );

    always_comb begin
        state_d        = state_q;
        ctl.load_color = 1'b0;
        ctl.send_it    = 1'b0;
        frame_done     = 1'b0;
        load_acc       = 1'b0;
        send_acc       = 1'b0;
        finish         = 1'b0;
        last_load      = (pixel_q == LAST_PIXEL) && (step_q == 2'd2);
        case (state_q)
            IDLE: begin
                // stop in the same cycle as start keeps the block idle
                if (start && !stop) state_d = LOAD;
            end
            LOAD: begin
                ctl.load_color = 1'b1;
                load_acc       = ctl.ready_to_load;
                if (stop)                       state_d = IDLE;
                else if (load_acc && last_load) state_d = SEND;
            end
            SEND: begin
                ctl.send_it = 1'b1;
                send_acc    = ctl.ready_to_send;
                if (send_acc) state_d = HOLD;
            end
            HOLD: begin
                if (hold_cnt_q == hold_len_q) begin
                    frame_done = 1'b1;
                    // a stop arriving on the final hold cycle is honoured too
                    finish  = stop_pend_q || stop || ((frame_q == last_q) && !loop_en);
                    state_d = finish ? IDLE : LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            last_q      <= '0;
            pixel_q     <= '0;
            step_q      <= '0;
            hold_cnt_q  <= '0;
            hold_len_q  <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if ((state_q == IDLE) && (state_d == LOAD)) last_q <= num_frames_m1;

            if (load_acc) begin
                if (step_q == 2'd2) begin
                    step_q  <= '0;
                    pixel_q <= last_load ? '0 : pixel_q + 1'b1;
                end else begin
                    step_q <= step_q + 1'b1;
                end
            end

            if (send_acc) begin
                hold_len_q <= hold_cycles;
                hold_cnt_q <= '0;
            end else if (state_q == HOLD) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end

            if (((state_q == SEND) || (state_q == HOLD)) && stop) stop_pend_q <= 1'b1;

            if ((state_q == HOLD) && (state_d == LOAD)) begin
                frame_q <= (frame_q == last_q) ? '0 : frame_q + 1'b1;
            end

            // Every way into IDLE leaves the counters ready for the next start,
            // including an abort in the middle of a frame.
            if (state_d == IDLE) begin
                frame_q     <= '0;
                pixel_q     <= '0;
                step_q      <= '0;
                stop_pend_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neo_frame_sequencer.sv
// tb/tb_neo_frame_sequencer.sv - self-checking bench for neo_frame_sequencer
`timescale 1ns/1ps
module tb_neo_frame_sequencer;

    localparam int NP = 5;
    localparam int NF = 4;
    localparam int HW = 24;

    logic          clock;
    logic          reset_n;
    logic          wr_en;
    logic [1:0]    wr_frame;
    logic [2:0]    wr_pixel;
    logic [1:0]    wr_color;
    logic [7:0]    wr_data;
    logic          start, stop, loop_en;
    logic [1:0]    num_frames_m1;
    logic [HW-1:0] hold_cycles;
    logic          running, frame_done;
    logic [1:0]    frame_idx;

    neo_frame_sequencer_if bus();

    neo_frame_sequencer #(.NUM_PIXELS(NP), .NUM_FRAMES(NF), .HOLD_W(HW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .wr_en         (wr_en),
        .wr_frame      (wr_frame),
        .wr_pixel      (wr_pixel),
        .wr_color      (wr_color),
        .wr_data       (wr_data),
        .start         (start),
        .stop          (stop),
        .loop_en       (loop_en),
        .num_frames_m1 (num_frames_m1),
        .hold_cycles   (hold_cycles),
        .ctl           (bus),
        .running       (running),
        .frame_idx     (frame_idx),
        .frame_done    (frame_done)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    int n_cmp, n_bad;
    logic [12:0] load_log[$], exp_loads[$];
    int done_log[$], hold_log[$], send_cyc[$], exp_frames[$];
    int send_cnt, overlap_cnt, stall_cycles, stall_bad, cyc;
    logic [7:0] model [NF][NP][3];
    int ctl_mode, stall_at, stall_left, busy, seen_sends;

    // Controller model: drives ready signals just after each rising edge.
    initial begin
        forever begin
            @(posedge clock); #1;
            if (send_cnt != seen_sends) begin
                seen_sends = send_cnt;
                busy = 2500;
            end
            case (ctl_mode)
                0: begin bus.ready_to_load = 1'b1; bus.ready_to_send = 1'b1; end
                1: begin
                    bus.ready_to_load = ($urandom_range(0, 3) != 0);
                    bus.ready_to_send = ($urandom_range(0, 2) == 0);
                end
                2: begin
                    bus.ready_to_send = 1'b1;
                    if (load_log.size() == stall_at && stall_left > 0) begin
                        bus.ready_to_load = 1'b0;
                        stall_left--;
                    end else begin
                        bus.ready_to_load = 1'b1;
                    end
                end
                3: begin
                    if (busy > 0) begin
                        busy--;
                        bus.ready_to_load = 1'b0; bus.ready_to_send = 1'b0;
                    end else begin
                        bus.ready_to_load = 1'b1; bus.ready_to_send = 1'b1;
                    end
                end
                default: begin bus.ready_to_load = 1'b1; bus.ready_to_send = 1'b0; end
            endcase
        end
    end

    // Monitor: samples the link on the falling edge.
    initial begin : monitor
        logic        prev_stall;
        logic [12:0] prev_vec, vec;
        prev_stall = 1'b0;
        prev_vec   = '0;
        forever begin
            @(negedge clock);
            cyc++;
            vec = {bus.pixel_index, bus.color_index, bus.color_level};
            if (bus.load_color && bus.ready_to_load) load_log.push_back(vec);
            if (bus.load_color && bus.send_it) overlap_cnt++;
            if (bus.send_it && bus.ready_to_send && !bus.load_color) begin
                send_cnt++;
                send_cyc.push_back(cyc);
            end
            if (frame_done) begin
                done_log.push_back(int'(frame_idx));
                hold_log.push_back(send_cyc.size() > 0 ? cyc - send_cyc[$] : -1);
            end
            if (bus.load_color && !bus.ready_to_load) stall_cycles++;
            if (prev_stall && bus.load_color && vec !== prev_vec) stall_bad++;
            prev_stall = bus.load_color && !bus.ready_to_load;
            prev_vec   = vec;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic host_write(input int f, input int p, input int c, input logic [7:0] d);
        tick();
        wr_en = 1'b1; wr_frame = 2'(f); wr_pixel = 3'(p); wr_color = 2'(c); wr_data = d;
        tick();
        wr_en = 1'b0;
        if (p < NP && c < 3) model[f][p][c] = d;
    endtask

    task automatic clear_logs();
        load_log.delete(); done_log.delete(); hold_log.delete(); send_cyc.delete();
        send_cnt = 0; seen_sends = 0; overlap_cnt = 0; stall_cycles = 0; stall_bad = 0;
    endtask

    task automatic play(input int nf, input logic lp, input int hold);
        clear_logs();
        tick();
        num_frames_m1 = 2'(nf); loop_en = lp; hold_cycles = HW'(hold); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clock);
            if (!running) break;
        end
        n_cmp++;
        if (i >= budget) begin
            n_bad++;
            $display("FAIL %s timeout: running=%b after %0d cycles, required 0", name, running, budget);
        end
    endtask

    // Expected load stream: every played frame, pixels in order, channels G,R,B.
    function automatic void build_expected();
        int c;
        exp_loads.delete();
        foreach (exp_frames[k])
            for (int p = 0; p < NP; p++)
                for (int s = 0; s < 3; s++) begin
                    c = (s == 0) ? 2 : (s == 1) ? 0 : 1;
                    exp_loads.push_back({3'(p), 2'(c), model[exp_frames[k]][p][c]});
                end
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock); reset_n = 1'b1;
        @(negedge clock);
        n_cmp++; if ({bus.load_color, bus.send_it, running, frame_done} !== 4'b0) begin
            n_bad++; $display("FAIL reset strobes: got %b, required 0000", {bus.load_color, bus.send_it, running, frame_done}); end
        n_cmp++; if (frame_idx !== 2'd0) begin n_bad++; $display("FAIL reset frame_idx: got %0d, required 0", frame_idx); end
        n_cmp++; if (bus.pixel_index !== 3'd0) begin n_bad++; $display("FAIL reset pixel_index: got %0d, required 0", bus.pixel_index); end
        n_cmp++; if (bus.color_index !== 2'd2) begin n_bad++; $display("FAIL reset color_index: got %0d, required 2", bus.color_index); end
        n_cmp++; if (bus.color_level !== 8'd0) begin n_bad++; $display("FAIL reset color_level: got %0d, required 0", bus.color_level); end
    endtask

    task automatic test_load_order();
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 3; c++) host_write(0, p, c, 8'(16 * p + c));
        ctl_mode = 0;
        play(0, 1'b0, 10);
        wait_idle(300, "load_order");
        exp_frames = '{0};
        build_expected();
        n_cmp++; if (load_log.size() != exp_loads.size()) begin n_bad++;
            $display("FAIL load_order count: got %0d, required %0d", load_log.size(), exp_loads.size()); end
        foreach (exp_loads[i]) if (i < load_log.size()) begin
            n_cmp++; if (load_log[i] !== exp_loads[i]) begin n_bad++;
                $display("FAIL load_order[%0d]: got %h, required %h", i, load_log[i], exp_loads[i]); end
        end
        n_cmp++; if (load_log.size() != 15 || load_log[0] !== {3'd0, 2'd2, 8'd2} || load_log[14] !== {3'd4, 2'd1, 8'd65}) begin
            n_bad++; $display("FAIL load_order ends: size %0d, required 15 loads from (0,2,2) to (4,1,65)", load_log.size()); end
        n_cmp++; if (send_cnt != 1) begin n_bad++; $display("FAIL load_order sends: got %0d, required 1", send_cnt); end
        n_cmp++; if (hold_log.size() != 1 || hold_log[0] != 11) begin n_bad++;
            $display("FAIL load_order hold: got %0d pulses, first %0d cycles, required 1 pulse after 11", hold_log.size(), hold_log.size() > 0 ? hold_log[0] : -1); end
        n_cmp++; if (overlap_cnt != 0) begin n_bad++; $display("FAIL load_order overlap: got %0d, required 0", overlap_cnt); end
    endtask

    task automatic test_stall();
        ctl_mode = 2; stall_at = 7; stall_left = 20;
        play(0, 1'b0, 3);
        wait_idle(300, "stall");
        exp_frames = '{0};
        build_expected();
        n_cmp++; if (load_log.size() != exp_loads.size()) begin n_bad++;
            $display("FAIL stall count: got %0d, required %0d", load_log.size(), exp_loads.size()); end
        foreach (exp_loads[i]) if (i < load_log.size()) begin
            n_cmp++; if (load_log[i] !== exp_loads[i]) begin n_bad++;
                $display("FAIL stall[%0d]: got %h, required %h", i, load_log[i], exp_loads[i]); end
        end
        n_cmp++; if (stall_cycles != 20) begin n_bad++; $display("FAIL stall cycles: got %0d, required 20", stall_cycles); end
        n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL stall frozen: got %0d changes, required 0", stall_bad); end
    endtask

    task automatic test_one_shot();
        int hold;
        for (int f = 1; f < NF; f++)
            for (int p = 0; p < NP; p++)
                for (int c = 0; c < 3; c++) host_write(f, p, c, 8'($urandom));
        // Out-of-range writes must be dropped, not alias into frame 1.
        host_write(0, 5, 0, 8'hAA); host_write(0, 7, 1, 8'hBB);
        host_write(0, 4, 3, 8'hCC); host_write(1, 6, 2, 8'hDD);
        hold = $urandom_range(0, 5);
        ctl_mode = 1;
        play(1, 1'b0, hold);
        wait_idle(1000, "one_shot");
        exp_frames = '{0, 1};
        build_expected();
        n_cmp++; if (load_log.size() != exp_loads.size()) begin n_bad++;
            $display("FAIL one_shot count: got %0d, required %0d", load_log.size(), exp_loads.size()); end
        foreach (exp_loads[i]) if (i < load_log.size()) begin
            n_cmp++; if (load_log[i] !== exp_loads[i]) begin n_bad++;
                $display("FAIL one_shot[%0d]: got %h, required %h", i, load_log[i], exp_loads[i]); end
        end
        n_cmp++; if (done_log.size() != 2 || done_log[0] != 0 || done_log[1] != 1) begin n_bad++;
            $display("FAIL one_shot frame_done: got %0d pulses, required 2 for frames 0,1", done_log.size()); end
        n_cmp++; if (send_cnt != 2) begin n_bad++; $display("FAIL one_shot sends: got %0d, required 2", send_cnt); end
        foreach (hold_log[i]) begin
            n_cmp++; if (hold_log[i] != hold + 1) begin n_bad++;
                $display("FAIL one_shot hold[%0d]: got %0d, required %0d", i, hold_log[i], hold + 1); end
        end
        n_cmp++; if (running !== 1'b0 || frame_idx !== 2'd0) begin n_bad++;
            $display("FAIL one_shot end: running %b frame_idx %0d, required 0 0", running, frame_idx); end
        n_cmp++; if (overlap_cnt != 0) begin n_bad++; $display("FAIL one_shot overlap: got %0d, required 0", overlap_cnt); end
    endtask

    task automatic test_loop();
        int hold, i;
        hold = $urandom_range(0, 5);
        ctl_mode = 1;
        play(3, 1'b1, hold);
        for (i = 0; i < 4000; i++) begin
            @(negedge clock);
            if (send_cnt == 6) break;
        end
        n_cmp++; if (i >= 4000) begin n_bad++; $display("FAIL loop sends timeout: got %0d, required 6", send_cnt); end
        tick(); stop = 1'b1;
        tick(); stop = 1'b0;
        wait_idle(100, "loop_stop");
        loop_en = 1'b0;
        exp_frames = '{0, 1, 2, 3, 0, 1};
        build_expected();
        n_cmp++; if (load_log.size() != exp_loads.size()) begin n_bad++;
            $display("FAIL loop count: got %0d, required %0d", load_log.size(), exp_loads.size()); end
        foreach (exp_loads[i]) if (i < load_log.size()) begin
            n_cmp++; if (load_log[i] !== exp_loads[i]) begin n_bad++;
                $display("FAIL loop[%0d]: got %h, required %h", i, load_log[i], exp_loads[i]); end
        end
        n_cmp++; if (done_log.size() != 6) begin n_bad++; $display("FAIL loop pulses: got %0d, required 6", done_log.size()); end
        foreach (exp_frames[k]) if (k < done_log.size()) begin
            n_cmp++; if (done_log[k] != exp_frames[k]) begin n_bad++;
                $display("FAIL loop frame_idx[%0d]: got %0d, required %0d", k, done_log[k], exp_frames[k]); end
        end
        n_cmp++; if (frame_idx !== 2'd0) begin n_bad++; $display("FAIL loop end frame_idx: got %0d, required 0", frame_idx); end
    endtask

    task automatic test_stop_in_load();
        int i;
        ctl_mode = 2; stall_at = 7; stall_left = 1000;
        play(0, 1'b0, 2);
        for (i = 0; i < 100; i++) begin
            @(negedge clock);
            if (load_log.size() == 7) break;
        end
        tick(); stop = 1'b1;
        tick(); stop = 1'b0;
        @(negedge clock);
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL stop_load running: got %b, required 0", running); end
        repeat (30) @(negedge clock);
        stall_left = 0;
        n_cmp++; if (load_log.size() != 7) begin n_bad++; $display("FAIL stop_load loads: got %0d, required 7", load_log.size()); end
        n_cmp++; if (send_cnt != 0) begin n_bad++; $display("FAIL stop_load sends: got %0d, required 0", send_cnt); end
        tick(); start = 1'b1; stop = 1'b1;
        tick(); start = 1'b0; stop = 1'b0;
        @(negedge clock);
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL start_stop running: got %b, required 0", running); end
    endtask

    task automatic test_reset_mid();
        int i;
        ctl_mode = 4;
        play(0, 1'b0, 0);
        for (i = 0; i < 200; i++) begin
            @(negedge clock);
            if (bus.send_it) break;
        end
        n_cmp++; if (i >= 200) begin n_bad++; $display("FAIL reset_mid send timeout: send_it %b, required 1", bus.send_it); end
        #3 reset_n = 1'b0;
        #1;
        n_cmp++; if ({bus.send_it, bus.load_color, running} !== 3'b000) begin n_bad++;
            $display("FAIL reset_mid async: got %b, required 000", {bus.send_it, bus.load_color, running}); end
        for (int f = 0; f < NF; f++) for (int p = 0; p < NP; p++) for (int c = 0; c < 3; c++) model[f][p][c] = 8'd0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        ctl_mode = 0;
        play(0, 1'b0, 0);
        wait_idle(200, "reset_mid");
        exp_frames = '{0};
        build_expected();
        n_cmp++; if (load_log.size() != exp_loads.size()) begin n_bad++;
            $display("FAIL reset_mid count: got %0d, required %0d", load_log.size(), exp_loads.size()); end
        foreach (exp_loads[i]) if (i < load_log.size()) begin
            n_cmp++; if (load_log[i] !== exp_loads[i]) begin n_bad++;
                $display("FAIL reset_mid[%0d]: got %h, required %h", i, load_log[i], exp_loads[i]); end
        end
    endtask

    task automatic test_long_wait();
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < NP; p++)
                for (int c = 0; c < 3; c++) host_write(f, p, c, 8'($urandom));
        ctl_mode = 3; busy = 0;
        play(1, 1'b0, 0);
        wait_idle(8000, "long_wait");
        exp_frames = '{0, 1};
        build_expected();
        n_cmp++; if (load_log.size() != exp_loads.size()) begin n_bad++;
            $display("FAIL long_wait count: got %0d, required %0d", load_log.size(), exp_loads.size()); end
        foreach (exp_loads[i]) if (i < load_log.size()) begin
            n_cmp++; if (load_log[i] !== exp_loads[i]) begin n_bad++;
                $display("FAIL long_wait[%0d]: got %h, required %h", i, load_log[i], exp_loads[i]); end
        end
        n_cmp++; if (send_cyc.size() != 2 || (send_cyc[1] - send_cyc[0]) < 2500) begin n_bad++;
            $display("FAIL long_wait sends: got %0d sends, required 2 at least 2500 cycles apart", send_cyc.size()); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        send_cnt = 0; seen_sends = 0; overlap_cnt = 0; stall_cycles = 0; stall_bad = 0;
        ctl_mode = 0; stall_at = 0; stall_left = 0; busy = 0;
        reset_n = 1'b0; wr_en = 1'b0; wr_frame = '0; wr_pixel = '0; wr_color = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; num_frames_m1 = '0; hold_cycles = '0;
        bus.ready_to_load = 1'b0; bus.ready_to_send = 1'b0;
        for (int f = 0; f < NF; f++) for (int p = 0; p < NP; p++) for (int c = 0; c < 3; c++) model[f][p][c] = 8'd0;
        test_reset();
        test_load_order();
        test_stall();
        test_one_shot();
        test_loop();
        test_stop_in_load();
        test_reset_mid();
        test_long_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/neo_frame_sequencer.md
Name: neo_frame_sequencer

Overview:
- Upstream feeder for the NeoPixel strand controller.
- Stores up to NUM_FRAMES colour frames, each NUM_PIXELS x {G,R,B} bytes, in an internal register array written by a host port.
- On start, streams one frame as per-channel load operations, then issues a send and holds for a programmable interval.
- Advances to the next frame, optionally looping, so the strand plays an animation without host involvement.

Parameters:
- NUM_PIXELS, 5, pixels per frame; legal range 1..8 because pixel_index is 3 bits.
- NUM_FRAMES, 4, frame slots in the store; power of two.
- HOLD_W, 24, width of the hold-interval counter.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  host write strobe.
- wr_frame  in  $clog2(NUM_FRAMES)  frame slot to write.
- wr_pixel  in  3  pixel to write; writes with wr_pixel >= NUM_PIXELS are ignored.
- wr_color  in  2  channel to write: 0=red, 1=blue, 2=green; 3 is ignored.
- wr_data  in  8  colour level.
- start  in  1  begin playback at frame 0; ignored unless IDLE.
- stop  in  1  request playback end.
- loop_en  in  1  wrap to frame 0 after the last frame.
- num_frames_m1  in  $clog2(NUM_FRAMES)  index of the last frame played; sampled at start.
- hold_cycles  in  HOLD_W  hold length after each send; sampled on SEND->HOLD.
- ready_to_load  in  1  from controller.
- ready_to_send  in  1  from controller.
- load_color  out  1  to controller.
- color_index  out  2  to controller.
- pixel_index  out  3  to controller.
- color_level  out  8  to controller.
- send_it  out  1  to controller.
- running  out  1  high whenever state != IDLE.
- frame_idx  out  $clog2(NUM_FRAMES)  frame currently being played.
- frame_done  out  1  one-cycle pulse on HOLD exit.

Behaviour:
- Reset: state IDLE, frame/pixel/channel counters 0, stop_pend 0, store cleared to 0.
- Output reset values: load_color 0, send_it 0, running 0, frame_idx 0, frame_done 0, pixel_index 0, color_index 2, color_level 0.
- Load acceptance rule: a load is accepted in any cycle with load_color && ready_to_load.
- Send acceptance rule: a send is accepted in any cycle with send_it && ready_to_send && !load_color. load_color and send_it are never high together.
- Load order per frame: pixel 0..NUM_PIXELS-1. Within each pixel, channel order is green(2), red(0), blue(1). That is 3*NUM_PIXELS loads per frame.
- color_level is a combinational read of store[frame_idx][pixel_index][color_index]; the value present in the acceptance cycle is the one loaded.
- Host write in the same cycle as a read of the same location: the read returns the old value and the write lands at the clock edge. Writes are accepted in every state.

State machine:
- IDLE: all strobes low. On start, latch num_frames_m1, clear frame_idx, go to LOAD.
- LOAD:
  - load_color=1, with pixel_index and color_index taken from the counters.
  - On acceptance, step channel G->R->B. B wraps to G and increments the pixel.
  - After the last accepted load, go to SEND.
  - If ready_to_load is low, hold all outputs stable.
- SEND: send_it=1 until accepted, then latch hold_cycles, clear the hold counter, go to HOLD.
- HOLD:
  - The hold counter increments each cycle. When count == hold_cycles, pulse frame_done, so HOLD lasts hold_cycles+1 cycles.
  - If stop_pend, or (frame_idx == last && !loop_en): go to IDLE and set frame_idx to 0.
  - Otherwise frame_idx increments (last wraps to 0) and go to LOAD.

Stop handling:
- stop in LOAD: go to IDLE next cycle. No send is issued; partially loaded controller registers are left as-is.
- stop in SEND or HOLD: sets stop_pend; the current send completes and the block exits at the end of HOLD.
- stop_pend clears on entry to IDLE.
- start and stop together in IDLE: stop wins and the block stays IDLE.

Reset mid-operation: all outputs return asynchronously to their reset values and the store is cleared.

Decomposition:
- Shared package neo_pkg:
  - colour index constants COLOR_RED=2'd0, COLOR_BLUE=2'd1, COLOR_GREEN=2'd2;
  - state enum {IDLE, LOAD, SEND, HOLD};
  - PIXEL_IDX_W=3, LEVEL_W=8.
- One natural sub-module: neo_frame_store, the register-array frame memory with a synchronous write port and a combinational read port.

Test Plan:
- Load order: frame 0 written with pixel p channel c = 16*p+c. Start with an always-ready controller model -> 15 loads with (pixel,color,level) = (0,2,2),(0,0,0),(0,1,1),(1,2,18)... ending (4,1,65); then exactly one accepted send_it; then HOLD lasts hold_cycles+1 = 11 cycles with hold_cycles=10.
- Stall: ready_to_load low for 20 cycles during load 7 -> all outputs frozen; the sequence resumes with no skip or duplicate.
- One-shot playback: num_frames_m1=1, loop_en=0 -> two frames sent, frame_done pulses twice, then running=0 and frame_idx=0.
- Looping: loop_en=1, num_frames_m1=3 -> frame_idx sequence 0,1,2,3,0,1 across frame_done pulses.
- Stop in LOAD: stop after 7 accepted loads -> IDLE next cycle, no send_it. Stop in HOLD -> the frame finishes and the block then goes IDLE.
- Reset mid-operation: reset_n low during SEND -> send_it, load_color, running drop asynchronously. After release, the store reads 0 and the block is IDLE.
- Real controller: integration run with the real controller at hold_cycles=0 -> the sequencer waits on ready_to_send through the controller's 2500-cycle wait, with no lost loads.
